ps2_direction_rx: RTL
=====================

PS2_DIRECTION_RX -- requirements
Module: ps2_direction_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, which is the mid-frame idle limit in clk cycles (1 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1 bit: system clock, 50 MHz; every register is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port KB_clk, input, 1 bit: PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 SHALL have port data, input, 1 bit: PS/2 data from the keyboard, asynchronous to clk.
REQ-006 SHALL have port direction, output, 5 bits: one-hot steering command (00010 up, 00100 left, 01000 down, 10000 right).
REQ-007 SHALL have port restart, output, 1 bit: one-cycle pulse requesting a game restart.
REQ-008 SHALL have port rx_byte, output, 8 bits: last byte received cleanly.
REQ-009 SHALL have port byte_valid, output, 1 bit: one-cycle pulse, high when rx_byte is new.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on parity error, stop-bit error or timeout.

Function
REQ-011 SHALL pass KB_clk and data each through a 2-flop synchronizer; a third flop on KB_clk gives fall = prev & ~sync (one cycle wide).
REQ-012 SHALL run a receive FSM with states IDLE, DATA, PARITY, STOP, advancing only on cycles where fall=1.
REQ-013 IDLE: on fall with data=0 (start bit), go to DATA and clear the bit counter; with data=1, stay in IDLE.
REQ-014 DATA: on each fall, shift data into the shift register LSB-first; after the 8th bit (counter 0..7, 3 bits), go to PARITY.
REQ-015 PARITY: on fall, store the sampled bit; parity is good when the XOR of the 8 data bits and the parity bit equals 1 (odd parity); go to STOP.
REQ-016 STOP: on fall with stop=1 and parity good, load rx_byte and assert byte_valid in the next cycle; otherwise assert frame_err in the next cycle; go to IDLE in both cases.
REQ-017 Timeout: a 16-bit counter clears on every fall and increments each cycle while not in IDLE; on reaching TIMEOUT_CYCLES, go to IDLE and pulse frame_err next cycle.
REQ-018 Timeout vs. edge: if fall occurs in the same cycle the counter reaches TIMEOUT_CYCLES, the fall wins; the counter clears and no error is raised.
REQ-019 Decode runs in the cycle byte_valid=1; its results register on the following edge, so direction/restart change 1 cycle after byte_valid.
REQ-020 Byte 0xE0 SHALL set ext_flag; byte 0xF0 SHALL set brk_flag; neither byte causes any other action.
REQ-021 Any other byte with brk_flag=1 is a release: no action; clear both flags.
REQ-022 Any other byte with brk_flag=0 is a make: act on it, then clear ext_flag.
REQ-023 Make map, ext_flag=0: 0x1D up, 0x1C left, 0x1B down, 0x23 right, 0x29 (space) restart.
REQ-024 Make map, ext_flag=1: 0x75 up, 0x6B left, 0x72 down, 0x74 right.
REQ-025 Unmapped make codes leave direction unchanged.
REQ-026 A requested direction exactly opposite the current one (up/down, left/right) SHALL be ignored; a request equal to the current one causes no change.
REQ-027 restart SHALL be high for exactly 1 cycle per space make; repeated typematic makes each produce a pulse.
REQ-028 frame_err SHALL clear ext_flag and brk_flag.
REQ-029 direction SHALL always be exactly one-hot.

Reset
REQ-030 While rst=1, regardless of clk: FSM=IDLE; counters, shift register, flags and synchronizers = 0 (KB_clk sync flops = 1); direction=10000; restart=0; rx_byte=0x00; byte_valid=0; frame_err=0.
REQ-031 rst asserted mid-frame SHALL abort the frame with no byte_valid and no frame_err; the first frame after release is received normally.

Verification
REQ-032 Frame 0x1D with good parity, sent at 12.5 kHz -> byte_valid pulse with rx_byte=0x1D; next cycle direction=00010.
REQ-033 Current direction right, frame 0x1C (left) -> byte_valid pulses, direction stays 10000; then 0x1D then 0x1C -> direction 00010, then 00100.
REQ-034 Sequence F0,1D, then E0,72 -> no change after the release; direction=01000 after 0x72; E0,F0,72 -> no change.
REQ-035 Frame 0x23 with flipped parity bit -> frame_err 1 cycle, no byte_valid, direction unchanged; a stop bit of 0 gives the same result.
REQ-036 Stop toggling KB_clk after 4 data bits -> frame_err exactly TIMEOUT_CYCLES+1 cycles after the last fall; the next good frame 0x29 -> one restart pulse.
REQ-037 Assert rst during the PARITY state -> all outputs at reset values immediately; no pulses; a subsequent frame 0x1B -> direction=01000.

Source files
------------

// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard receiver that turns arrow/WASD-style make codes into a one-hot
// steering command and a one-cycle restart pulse on the space bar.
module ps2_direction_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       KB_clk,
    input  logic       data,
    output logic [4:0] direction,
    output logic       restart,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // The timeout fires on the edge where the idle counter would step onto the limit.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    logic        kb_clk_s1, kb_clk_s2, kb_clk_prev;
    logic        data_s1, data_s2;
    logic        fall;
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic        parity_good;
    logic [15:0] idle_cnt;
    logic        timeout_hit;
    logic        frame_ok, frame_bad;
    logic        ext_flag, brk_flag;
    logic [4:0]  req_dir, opp_dir;
    logic        is_space;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_clk_s1   <= 1'b1;
            kb_clk_s2   <= 1'b1;
            kb_clk_prev <= 1'b1;
            data_s1     <= 1'b0;
            data_s2     <= 1'b0;
        end else begin
            kb_clk_s1   <= KB_clk;
            kb_clk_s2   <= kb_clk_s1;
            kb_clk_prev <= kb_clk_s2;
            data_s1     <= data;
            data_s2     <= data_s1;
        end
    end

    assign fall        = kb_clk_prev & ~kb_clk_s2;
    assign parity_good = ^{shift_q, parity_q};
    assign timeout_hit = (state_q != IDLE) && !fall && (idle_cnt == TIMEOUT_LAST);

    always_comb begin
        state_d   = state_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!data_s2) state_d = DATA;
                DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (data_s2 && parity_good) frame_ok  = 1'b1;
                    else                        frame_bad = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt    <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            idle_cnt   <= 16'd0;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_valid <= frame_ok;
            frame_err  <= frame_bad | timeout_hit;
            if (frame_ok) rx_byte <= shift_q;
            if (state_q == IDLE || fall || timeout_hit) idle_cnt <= 16'd0;
            else                                         idle_cnt <= idle_cnt + 16'd1;
            if (fall && !timeout_hit) begin
                case (state_q)
                    IDLE: bit_cnt <= 3'd0;
                    DATA: begin
                        shift_q <= {data_s2, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  parity_q <= data_s2;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        req_dir  = 5'b00000;
        is_space = 1'b0;
        case ({ext_flag, rx_byte})
            9'h01D:  req_dir  = DIR_UP;
            9'h01C:  req_dir  = DIR_LEFT;
            9'h01B:  req_dir  = DIR_DOWN;
            9'h023:  req_dir  = DIR_RIGHT;
            9'h029:  is_space = 1'b1;
            9'h175:  req_dir  = DIR_UP;
            9'h16B:  req_dir  = DIR_LEFT;
            9'h172:  req_dir  = DIR_DOWN;
            9'h174:  req_dir  = DIR_RIGHT;
            default: req_dir  = 5'b00000;
        endcase
        // Swap up<->down and left<->right to get the forbidden reversal.
        opp_dir = {req_dir[2], req_dir[1], req_dir[4], req_dir[3], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            direction <= DIR_RIGHT;
            restart   <= 1'b0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
        end else begin
            restart <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (brk_flag) begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end else begin
                    ext_flag <= 1'b0;
                    restart  <= is_space;
                    if (req_dir != 5'b00000 && direction != opp_dir) direction <= req_dir;
                end
            end
        end
    end

endmodule
